// File: rtl/sd_read_scheduler_pkg.sv
// Shared types for the SD block-read scheduler.
// Block geometry, address type, FSM states, index-width helper.
package sd_pkg;

  localparam int SD_BLOCK_BYTES = 512;

  typedef logic [22:0] sd_block_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    STREAM,
    BLKEND,
    ERROR
  } sd_sched_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_read_scheduler_if.sv
// Requester-side and card-side bundles of the SD read scheduler.
// master drives requests / triggers, slave answers.
interface sd_req_if #(
  parameter int NUM_REQ = 2
);
  import sd_pkg::*;

  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*23-1:0] req_block;
  logic [NUM_REQ*16-1:0] req_count;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic [IW-1:0]         out_dst;
  logic [8:0]            out_offset;
  logic                  out_last;

  modport master (
    output req, req_block, req_count,
    input  grant, done, err,
    input  out_byte, out_valid, out_dst,
    input  out_offset, out_last
  );

  modport slave (
    input  req, req_block, req_count,
    output grant, done, err,
    output out_byte, out_valid, out_dst,
    output out_offset, out_last
  );

endinterface

interface sd_card_if;
  import sd_pkg::*;

  logic           sd_trigger;
  sd_block_addr_t sd_block_addr;
  logic           sd_ready;
  logic [7:0]     sd_byte;
  logic           sd_byte_valid;

  modport master (
    output sd_trigger, sd_block_addr,
    input  sd_ready, sd_byte, sd_byte_valid
  );

  modport slave (
    input  sd_trigger, sd_block_addr,
    output sd_ready, sd_byte, sd_byte_valid
  );

endinterface

// File: rtl/sd_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Returns one-hot grant plus its binary index.
module rr_arbiter
  import sd_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int   j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sd_read_scheduler.sv
// Round-robin scheduler in front of a single sd_reader.
// Splits multi-block reads into single-block triggers and tags bytes.
module sd_read_scheduler
  import sd_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic      clk,
  input  logic      rst,
  sd_req_if.slave   rq,
  sd_card_if.master sd
);

  localparam int IW  = idx_w(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WDW-1:0] WD_LIM =
    WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] LAST_B =
    10'(SD_BLOCK_BYTES - 1);

  sd_sched_state_t state_q, state_d;

  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  sd_block_addr_t     addr_q, addr_d;
  logic [15:0]        remain_q, remain_d;
  logic [9:0]         bcnt_q, bcnt_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         ob_q, ob_d;
  logic               ov_q, ov_d;
  logic [IW-1:0]      od_q, od_d;
  logic [8:0]         oo_q, oo_d;
  logic               ol_q, ol_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  sd_block_addr_t     req_blk;
  logic [15:0]        req_cnt;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i (rq.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign req_blk = rq.req_block[23*int'(arb_idx) +: 23];
  assign req_cnt = rq.req_count[16*int'(arb_idx) +: 16];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    bcnt_d   = bcnt_q;
    wd_d     = wd_q;
    err_d    = err_q;
    grant_d  = grant_q;
    done_d   = '0;
    ob_d     = ob_q;
    ov_d     = 1'b0;
    od_d     = od_q;
    oo_d     = oo_q;
    ol_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // the cycle showing done still sees the old req level
        if (sd.sd_ready && (|rq.req) && !(|done_q)) begin
          owner_d  = arb_idx;
          grant_d  = arb_gnt;
          addr_d   = req_blk;
          remain_d = (req_cnt == 16'd0) ? 16'd1 : req_cnt;
          bcnt_d   = '0;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        wd_d    = WDW'(1);
        state_d = BUSY;
      end

      BUSY, STREAM, BLKEND: begin
        if (wd_q == WD_LIM) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          state_d = ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
          unique case (state_q)
            BUSY: begin
              if (!sd.sd_ready) state_d = STREAM;
            end
            STREAM: begin
              if (sd.sd_byte_valid) begin
                ob_d = sd.sd_byte;
                ov_d = 1'b1;
                od_d = owner_q;
                oo_d = bcnt_q[8:0];
                ol_d = (bcnt_q == LAST_B) &&
                       (remain_q == 16'd1);
                if (bcnt_q == LAST_B) begin
                  bcnt_d  = '0;
                  state_d = BLKEND;
                end else begin
                  bcnt_d = bcnt_q + 1'b1;
                end
              end
            end
            default: begin
              if (sd.sd_ready) begin
                if (remain_q > 16'd1) begin
                  remain_d = remain_q - 16'd1;
                  addr_d   = addr_q + 23'd1;
                  state_d  = ISSUE;
                end else begin
                  done_d  = grant_q;
                  grant_d = '0;
                  if (owner_q == IW'(NUM_REQ - 1))
                    ptr_d = '0;
                  else
                    ptr_d = owner_q + 1'b1;
                  state_d = IDLE;
                end
              end
            end
          endcase
        end
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      bcnt_q   <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      ob_q     <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      oo_q     <= '0;
      ol_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      bcnt_q   <= bcnt_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      ob_q     <= ob_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      oo_q     <= oo_d;
      ol_q     <= ol_d;
    end
  end

  assign rq.grant      = grant_q;
  assign rq.done       = done_q;
  assign rq.err        = err_q;
  assign rq.out_byte   = ob_q;
  assign rq.out_valid  = ov_q;
  assign rq.out_dst    = od_q;
  assign rq.out_offset = oo_q;
  assign rq.out_last   = ol_q;

  assign sd.sd_trigger    = (state_q == ISSUE);
  assign sd.sd_block_addr = addr_q;

endmodule
